pipeline_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage RV32I pipeline (F,D,X,M,W plus post-W regfile write stage WB).

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/hazard_match.sv | 24 ++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
//   fwd_sel_e   : X-stage operand source select (regfile, X/M, M/W, WB stage)
//   trk_entry_t : one in-flight destination tracking entry
//   fsm_e       : run/stall sequencing state
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_XM = 2'b01,
    FWD_MW = 2'b10,
    FWD_WB = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwren;
    logic       memren;
  } trk_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_e;

  // Number of tracked in-flight producers (X, M, W).
  localparam int TRK_DEPTH = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam trk_entry_t TRK_EMPTY = '{valid: 1'b0, rd: 5'd0, regwren: 1'b0, memren: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Single source/producer comparator.
// Ports:
//   entry  : in-flight producer tracking entry
//   rs     : consumer source register index
//   rs_use : consumer actually reads rs
//   hit    : producer will write the register the consumer reads
// x0 is hard-wired zero, so a producer targeting x0 never matches.
module hazard_match
  import pipe_ctrl_pkg::*;
(
  input  trk_entry_t entry,
  input  logic [4:0] rs,
  input  logic       rs_use,
  output logic       hit
);

  // The load flag is consumed by the top only for the X entry.
  logic unused_memren;
  assign unused_memren = entry.memren;

  assign hit = entry.valid & entry.regwren & (entry.rd != REG_ZERO) &
               (entry.rd == rs) & rs_use;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline (F,D,X,M,W + WB).
// Tracks destination registers of the instructions in X, M and W, detects
// load-use hazards for the instruction in D, steers redirects, registers the
// X-stage forwarding selects and keeps saturating stall/flush counters.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   freeze_i              : global hold, nothing advances, controls forced 0
//   d_valid_i, d_rs*_i    : D-stage instruction sources and their use flags
//   d_rd_i, d_regwren_i,
//   d_memren_i            : D-stage destination, write enable, load flag
//   x_redirect_i          : X-stage taken branch/jump
//   pc_hold_o, fd_hold_o,
//   dx_bubble_o           : load-use stall controls
//   fd_flush_o, dx_flush_o: redirect squash controls
//   fwd_rs1_sel_o/rs2     : registered X operand source selects
//   stall_cnt_o, flush_cnt_o : saturating performance counters
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze_i,
  input  logic             d_valid_i,
  input  logic [4:0]       d_rs1_i,
  input  logic [4:0]       d_rs2_i,
  input  logic             d_rs1_use_i,
  input  logic             d_rs2_use_i,
  input  logic [4:0]       d_rd_i,
  input  logic             d_regwren_i,
  input  logic             d_memren_i,
  input  logic             x_redirect_i,
  output logic             pc_hold_o,
  output logic             fd_hold_o,
  output logic             dx_bubble_o,
  output logic             fd_flush_o,
  output logic             dx_flush_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Tracking entries: _p0 = instruction in X, _p1 = in M, _p2 = in W.
  trk_entry_t               trk_p0, trk_p1, trk_p2;
  trk_entry_t [TRK_DEPTH-1:0] trk_vec;
  trk_entry_t               trk_in;

  fsm_e       state, state_nxt;
  logic [TRK_DEPTH-1:0] hit_rs1, hit_rs2;
  logic       load_use;
  logic       stall;
  logic       flush;
  fwd_sel_e   fwd1_p0, fwd2_p0;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic fwd_sel_e pick_fwd(input logic [TRK_DEPTH-1:0] hit);
    // Youngest producer holds the most recent value.
    if (hit[0])      return FWD_XM;
    else if (hit[1]) return FWD_MW;
    else if (hit[2]) return FWD_WB;
    else             return FWD_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign trk_vec = {trk_p2, trk_p1, trk_p0};

  for (genvar i = 0; i < TRK_DEPTH; i++) begin : g_match
    hazard_match u_rs1 (
      .entry  (trk_vec[i]),
      .rs     (d_rs1_i),
      .rs_use (d_rs1_use_i),
      .hit    (hit_rs1[i])
    );
    hazard_match u_rs2 (
      .entry  (trk_vec[i]),
      .rs     (d_rs2_i),
      .rs_use (d_rs2_use_i),
      .hit    (hit_rs2[i])
    );
  end

  // A loaded value is only available once the load leaves M, so a consumer
  // directly behind a load must wait one cycle.
  assign load_use = d_valid_i & trk_p0.memren & (hit_rs1[0] | hit_rs2[0]);

  // Redirect beats load-use: the D instruction is squashed anyway.
  // Under freeze or reset no control is asserted; the condition is
  // re-evaluated once the pipeline can move again.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!reset && !freeze_i) begin
      if (x_redirect_i) begin
        flush = 1'b1;
      end else if (load_use && (state == RUN)) begin
        stall = 1'b1;
      end
    end
  end

  assign pc_hold_o   = stall;
  assign fd_hold_o   = stall;
  assign dx_bubble_o = stall;
  assign fd_flush_o  = flush;
  assign dx_flush_o  = flush;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // A stall lasts exactly one advancing cycle.
  always_comb begin
    state_nxt = state;
    if (!freeze_i) begin
      if (stall) state_nxt = STALL;
      else       state_nxt = RUN;
    end
  end

  always_comb begin
    trk_in = TRK_EMPTY;
    if (d_valid_i && !stall && !flush) begin
      trk_in = '{valid: 1'b1, rd: d_rd_i, regwren: d_regwren_i, memren: d_memren_i};
    end
  end

  // D -> X boundary: tracking shift and forwarding select registers
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_p0  <= TRK_EMPTY;
      trk_p1  <= TRK_EMPTY;
      trk_p2  <= TRK_EMPTY;
      fwd1_p0 <= FWD_RF;
      fwd2_p0 <= FWD_RF;
    end else if (!freeze_i) begin
      trk_p0 <= trk_in;
      trk_p1 <= trk_p0;
      trk_p2 <= trk_p1;
      if (!d_valid_i || stall || flush) begin
        fwd1_p0 <= FWD_RF;
        fwd2_p0 <= FWD_RF;
      end else begin
        fwd1_p0 <= pick_fwd(hit_rs1);
        fwd2_p0 <= pick_fwd(hit_rs2);
      end
    end
  end

  assign fwd_rs1_sel_o = fwd1_p0;
  assign fwd_rs2_sel_o = fwd2_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected per-cycle
// outputs from an instruction-history model; a monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, freeze, dv, u1, u2, we, ld, redir;
  logic [4:0]    s1, s2, rd;
  logic          pc_hold, fd_hold, dx_bubble, fd_flush, dx_flush;
  logic [1:0]    f1, f2;
  logic [CW-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .freeze_i      (freeze),
    .d_valid_i     (dv),
    .d_rs1_i       (s1),
    .d_rs2_i       (s2),
    .d_rs1_use_i   (u1),
    .d_rs2_use_i   (u2),
    .d_rd_i        (rd),
    .d_regwren_i   (we),
    .d_memren_i    (ld),
    .x_redirect_i  (redir),
    .pc_hold_o     (pc_hold),
    .fd_hold_o     (fd_hold),
    .dx_bubble_o   (dx_bubble),
    .fd_flush_o    (fd_flush),
    .dx_flush_o    (dx_flush),
    .fwd_rs1_sel_o (f1),
    .fwd_rs2_sel_o (f2),
    .stall_cnt_o   (scnt),
    .flush_cnt_o   (fcnt)
  );

  typedef struct {
    logic          pc_hold, fd_hold, bubble, fflush, xflush;
    logic [1:0]    f1, f2;
    logic [CW-1:0] sc, fc;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ins_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  // Instructions that entered X over the last three advancing cycles:
  // hist[0] now in X, hist[1] in M, hist[2] in W.
  ins_t          hist[3];
  logic [1:0]    m_f1, m_f2;
  logic [CW-1:0] m_sc, m_fc;

  function automatic logic writes(input ins_t p, input logic [4:0] rs, input logic use_rs);
    return p.valid && p.we && (p.rd != 5'd0) && (p.rd == rs) && use_rs;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input logic use_rs);
    for (int k = 0; k < 3; k++)
      if (writes(hist[k], rs, use_rs)) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
    m_f1 = 2'd0; m_f2 = 2'd0; m_sc = '0; m_fc = '0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic [4:0] d,
                       input logic w, input logic l, input logic x);
    exp_t e;
    logic lu, st, fl;
    ins_t nw;
    @(posedge clk); #1;
    reset = r; freeze = f; dv = v; s1 = a; s2 = b; u1 = ua; u2 = ub;
    rd = d; we = w; ld = l; redir = x;
    lu = v && hist[0].ld && (writes(hist[0], a, ua) || writes(hist[0], b, ub));
    fl = !r && !f && x;
    st = !r && !f && !x && lu;
    e.pc_hold = st; e.fd_hold = st; e.bubble = st;
    e.fflush = fl; e.xflush = fl;
    e.f1 = m_f1; e.f2 = m_f2; e.sc = m_sc; e.fc = m_fc;
    expq.push_back(e);
    if (r) begin
      model_clear();
    end else if (!f) begin
      if (!v || st || fl) begin
        m_f1 = 2'd0; m_f2 = 2'd0;
      end else begin
        m_f1 = fwd_of(a, ua); m_f2 = fwd_of(b, ub);
      end
      nw = '{v && !st && !fl, d, w, l};
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nw;
      if (st && m_sc != '1) m_sc = m_sc + 1'b1;
      if (fl && m_fc != '1) m_fc = m_fc + 1'b1;
    end
  endtask

  // Normal instruction in D: rd, rs1, rs2, uses, writes, load
  task automatic ins(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                     input logic ua, input logic ub, input logic w, input logic l);
    cycle(1'b0, 1'b0, 1'b1, a, b, ua, ub, d, w, l, 1'b0);
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_hold",   int'(pc_hold),   int'(e.pc_hold));
        chk("fd_hold",   int'(fd_hold),   int'(e.fd_hold));
        chk("dx_bubble", int'(dx_bubble), int'(e.bubble));
        chk("fd_flush",  int'(fd_flush),  int'(e.fflush));
        chk("dx_flush",  int'(dx_flush),  int'(e.xflush));
        chk("fwd_rs1",   int'(f1),        int'(e.f1));
        chk("fwd_rs2",   int'(f2),        int'(e.f2));
        chk("stall_cnt", int'(scnt),      int'(e.sc));
        chk("flush_cnt", int'(fcnt),      int'(e.fc));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; freeze = 1'b0; dv = 1'b0; s1 = '0; s2 = '0; u1 = 1'b0; u2 = 1'b0;
    rd = '0; we = 1'b0; ld = 1'b0; redir = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();
    nop();

    // addi x5,x0,1 ; add x6,x5,x5 -> both selects X/M
    ins(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ins(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    nop(); nop();

    // lw x5 ; add x6,x5,x0 -> one stall, then M/W forward
    ins(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    nop(); nop();

    // producer x7, two unrelated, consumer -> WB; gap of three -> regfile
    ins(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ins(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd10, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ins(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ins(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    ins(5'd10, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    nop();

    // lw x0 ; add x6,x0,x0 -> no stall, regfile
    ins(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    ins(5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    nop();

    // redirect with a load-use pending in the same cycle
    ins(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    ins(5'd12, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    nop(); nop();

    // freeze for three cycles during a stall, then release
    ins(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    nop();

    // reset mid-stall
    ins(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    nop();

    // randomized traffic on a small register set to provoke hazards and
    // drive both counters into saturation
    for (int i = 0; i < 600; i++) begin
      logic w, l;
      w = ($urandom_range(3) != 0);
      l = w && ($urandom_range(2) == 0);
      cycle(($urandom_range(99) == 0), ($urandom_range(7) == 0), ($urandom_range(7) != 0),
            5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            5'($urandom_range(3)), w, l, ($urandom_range(9) == 0));
    end

    @(posedge clk); #1;
    redir = 1'b0; dv = 1'b0; freeze = 1'b1;
    @(posedge clk); #1;
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
